// File: rtl/fu_sequencer.sv
// ---------------------------------------------------------------------------
// fu_sequencer
//
// Issue controller placed in front of functional_unit. Requests are accepted
// over a valid/ready handshake, launched to the FU on the falling edge of
// CLOCK (so INST is stable through the FU's low-phase capture window), and
// their results are collected once the per-class latency expires. Results
// are returned in order, tagged, through a response FIFO. Request acceptance
// is credit-protected, so a result always has a FIFO slot waiting for it.
//
// Optional feature (macro FU_SEQ_STATS_EN): adds saturating issue and stall
// counters on the STAT_ISSUE / STAT_STALL outputs. With the macro undefined
// those ports and counters do not exist.
//
// Parameters
//   MADD_LAT    FU rising edges from MADD capture until its result is on FU_Z (1..7)
//   FIFO_DEPTH  response FIFO entries (power of two, 2..16)
//   TAG_W       request/response tag width
//
// Ports
//   CLOCK, RESET_N        clock; asynchronous active-low reset
//   REQ_VALID/REQ_READY   request handshake
//   REQ_INST/A/B/C        opcode and operands
//   REQ_SELECT, REQ_TAG   select bit and tag echoed on the response
//   FU_INST/A/B/C/SELECT  falling-edge launch registers driving the FU
//   FU_Z, FU_COMPARE      FU result and compare flag
//   RSP_VALID/RSP_READY   response handshake (FIFO head)
//   RSP_Z/COMPARE/TAG     response payload at the FIFO head
//   STAT_ISSUE/STAT_STALL accept and stall counters (FU_SEQ_STATS_EN only)
// ---------------------------------------------------------------------------
module fu_sequencer #(
   parameter int MADD_LAT   = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic [5:0]       REQ_INST,
   input  logic [31:0]      REQ_A,
   input  logic [31:0]      REQ_B,
   input  logic [31:0]      REQ_C,
   input  logic             REQ_SELECT,
   input  logic [TAG_W-1:0] REQ_TAG,
   output logic [5:0]       FU_INST,
   output logic [31:0]      FU_A,
   output logic [31:0]      FU_B,
   output logic [31:0]      FU_C,
   output logic             FU_SELECT,
   input  logic [31:0]      FU_Z,
   input  logic             FU_COMPARE,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic [31:0]      RSP_Z,
   output logic             RSP_COMPARE,
   output logic [TAG_W-1:0] RSP_TAG
`ifdef FU_SEQ_STATS_EN
   ,
   output logic [15:0]      STAT_ISSUE,
   output logic [15:0]      STAT_STALL
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [2:0]     LAT_V   = 3'(MADD_LAT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STREAM    = 2'd1,
      MADD_WAIT = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       madd_cnt, madd_cnt_nxt;

   logic             acc;
   logic             is_madd;
   logic             push;
   logic             pop;

   logic [CNT_W-1:0] fifo_cnt, fifo_nxt;
   logic [CNT_W-1:0] infl_cnt, infl_nxt;
   logic [CNT_W:0]   used_nxt;

   // Launch stage: request fields captured on the accepting rising edge.
   logic             vld_p0;
   logic [5:0]       inst_p0;
   logic [31:0]      a_p0;
   logic [31:0]      b_p0;
   logic [31:0]      c_p0;
   logic             sel_p0;

   // In-flight pipe. Slot k holds an op whose result is captured k+1 edges
   // later; slot 0 is captured at the next rising edge.
   logic [MADD_LAT:0] pipe_vld;
   logic [TAG_W-1:0]  pipe_tag [0:MADD_LAT];

   // Response FIFO storage and the register that holds the last popped head.
   logic [31:0]      mem_z   [0:FIFO_DEPTH-1];
   logic             mem_cmp [0:FIFO_DEPTH-1];
   logic [TAG_W-1:0] mem_tag [0:FIFO_DEPTH-1];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [31:0]      hold_z;
   logic             hold_cmp;
   logic [TAG_W-1:0] hold_tag;

   assign acc     = REQ_VALID & REQ_READY;
   assign is_madd = (REQ_INST[5:3] == 3'b111);
   assign push    = pipe_vld[0];
   assign pop     = RSP_VALID & RSP_READY;

   // Occupancy after this edge. Credits are derived from these so that the
   // registered REQ_READY reflects the state the next cycle starts from; a
   // pop therefore frees its credit only one cycle later.
   always_comb begin
      fifo_nxt = fifo_cnt;
      if (push && !pop)
         fifo_nxt = fifo_cnt + CNT_W'(1);
      else if (!push && pop)
         fifo_nxt = fifo_cnt - CNT_W'(1);

      infl_nxt = infl_cnt;
      if (acc && !push)
         infl_nxt = infl_cnt + CNT_W'(1);
      else if (!acc && push)
         infl_nxt = infl_cnt - CNT_W'(1);

      used_nxt = {1'b0, fifo_nxt} + {1'b0, infl_nxt};
   end

   // Next-state logic. The MADD counter reaches zero on the edge before the
   // MADD result is captured; the capture edge itself returns to IDLE. Any
   // single-cycle ops issued ahead of the MADD have already drained by then.
   always_comb begin
      state_nxt    = state;
      madd_cnt_nxt = madd_cnt;
      if (acc && is_madd) begin
         state_nxt    = MADD_WAIT;
         madd_cnt_nxt = LAT_V;
      end else if (state == MADD_WAIT) begin
         if (madd_cnt == 3'd0)
            state_nxt = IDLE;
         else
            madd_cnt_nxt = madd_cnt - 3'd1;
      end else if (acc) begin
         state_nxt = STREAM;
      end else if (infl_nxt == '0) begin
         state_nxt = IDLE;
      end else begin
         state_nxt = STREAM;
      end
   end

   // ---- rising edge: control, in-flight pipe valid, FIFO pointers ----
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         madd_cnt  <= 3'd0;
         fifo_cnt  <= '0;
         infl_cnt  <= '0;
         REQ_READY <= 1'b0;
         vld_p0    <= 1'b0;
         pipe_vld  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         state     <= state_nxt;
         madd_cnt  <= madd_cnt_nxt;
         fifo_cnt  <= fifo_nxt;
         infl_cnt  <= infl_nxt;
         REQ_READY <= (state_nxt != MADD_WAIT) && (used_nxt < DEPTH_V);
         vld_p0    <= acc;

         pipe_vld <= {1'b0, pipe_vld[MADD_LAT:1]};
         if (acc) begin
            if (is_madd)
               pipe_vld[MADD_LAT] <= 1'b1;
            else
               pipe_vld[1] <= 1'b1;
         end

         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Data-only registers: qualified by the valids above, so no reset needed.
   always_ff @(posedge CLOCK) begin
      if (acc) begin
         inst_p0 <= REQ_INST;
         a_p0    <= REQ_A;
         b_p0    <= REQ_B;
         c_p0    <= REQ_C;
         sel_p0  <= REQ_SELECT;
      end

      for (int i = 0; i < MADD_LAT; i++)
         pipe_tag[i] <= pipe_tag[i+1];
      if (acc) begin
         if (is_madd)
            pipe_tag[MADD_LAT] <= REQ_TAG;
         else
            pipe_tag[1] <= REQ_TAG;
      end

      if (push) begin
         mem_z[wr_ptr]   <= FU_Z;
         mem_cmp[wr_ptr] <= FU_COMPARE;
         mem_tag[wr_ptr] <= pipe_tag[0];
      end
   end

   // Last popped head, shown while the FIFO is empty.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         hold_z   <= '0;
         hold_cmp <= 1'b0;
         hold_tag <= '0;
      end else if (pop) begin
         hold_z   <= mem_z[rd_ptr];
         hold_cmp <= mem_cmp[rd_ptr];
         hold_tag <= mem_tag[rd_ptr];
      end
   end

   // ---- falling edge: FU launch registers ----
   // They only change when an op was accepted on the preceding rising edge,
   // which keeps the FU inputs steady while a MADD is in flight.
   always_ff @(negedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         FU_INST   <= 6'd0;
         FU_A      <= 32'd0;
         FU_B      <= 32'd0;
         FU_C      <= 32'd0;
         FU_SELECT <= 1'b0;
      end else if (vld_p0) begin
         FU_INST   <= inst_p0;
         FU_A      <= a_p0;
         FU_B      <= b_p0;
         FU_C      <= c_p0;
         FU_SELECT <= sel_p0;
      end
   end

   assign RSP_VALID   = (fifo_cnt != '0);
   assign RSP_Z       = RSP_VALID ? mem_z[rd_ptr]   : hold_z;
   assign RSP_COMPARE = RSP_VALID ? mem_cmp[rd_ptr] : hold_cmp;
   assign RSP_TAG     = RSP_VALID ? mem_tag[rd_ptr] : hold_tag;

`ifdef FU_SEQ_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         STAT_ISSUE <= 16'd0;
         STAT_STALL <= 16'd0;
      end else begin
         if (acc)
            STAT_ISSUE <= sat_inc16(STAT_ISSUE);
         if (REQ_VALID && !REQ_READY)
            STAT_STALL <= sat_inc16(STAT_STALL);
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fu_sequencer.sv
module tb_fu_sequencer;

   localparam int MADD_LAT   = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 4;

   localparam logic [5:0] OP_ADD  = 6'b000010;
   localparam logic [5:0] OP_INC  = 6'b000110;
   localparam logic [5:0] OP_LT   = 6'b001110;
   localparam logic [5:0] OP_MADD = 6'b111100;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [5:0]       req_inst;
   logic [31:0]      req_a, req_b, req_c;
   logic             req_select;
   logic [TAG_W-1:0] req_tag;
   logic [5:0]       fu_inst;
   logic [31:0]      fu_a, fu_b, fu_c;
   logic             fu_select;
   logic [31:0]      fu_z;
   logic             fu_compare;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_z;
   logic             rsp_compare;
   logic [TAG_W-1:0] rsp_tag;
`ifdef FU_SEQ_STATS_EN
   logic [15:0]      stat_issue;
   logic [15:0]      stat_stall;
`endif

   int   n_chk = 0;
   int   n_fail = 0;
   int   n_iss = 0;
   int   n_stl = 0;
   logic b_acc;

   always #5 clk = ~clk;

   fu_sequencer #(.MADD_LAT(MADD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
      .CLOCK(clk), .RESET_N(rst_n),
      .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_INST(req_inst),
      .REQ_A(req_a), .REQ_B(req_b), .REQ_C(req_c),
      .REQ_SELECT(req_select), .REQ_TAG(req_tag),
      .FU_INST(fu_inst), .FU_A(fu_a), .FU_B(fu_b), .FU_C(fu_c),
      .FU_SELECT(fu_select), .FU_Z(fu_z), .FU_COMPARE(fu_compare),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_Z(rsp_z),
      .RSP_COMPARE(rsp_compare), .RSP_TAG(rsp_tag)
`ifdef FU_SEQ_STATS_EN
      , .STAT_ISSUE(stat_issue), .STAT_STALL(stat_stall)
`endif
   );

   // Functional unit stand-in: single-cycle ops answer one edge after
   // capture, MADD answers MADD_LAT edges after capture.
   logic [31:0] sc_z;
   logic        sc_cmp;
   logic [31:0] madd_sr [0:MADD_LAT-1];
   logic        last_madd;

   always @(posedge clk) begin
      case (fu_inst)
         OP_ADD:  begin sc_z <= fu_a + fu_b; sc_cmp <= 1'b0; end
         OP_INC:  begin sc_z <= fu_a + 32'd1; sc_cmp <= 1'b0; end
         OP_LT:   begin sc_z <= 32'd0; sc_cmp <= ($signed(fu_a) < $signed(fu_b)); end
         default: begin sc_z <= 32'd0; sc_cmp <= 1'b0; end
      endcase
      madd_sr[0] <= fu_a * fu_b + fu_c;
      for (int k = MADD_LAT - 1; k > 0; k--)
         madd_sr[k] <= madd_sr[k-1];
      last_madd <= (fu_inst[5:3] == 3'b111);
   end

   assign fu_z       = last_madd ? madd_sr[MADD_LAT-1] : sc_z;
   assign fu_compare = last_madd ? 1'b0 : sc_cmp;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge, noting whether the
   // handshake presented just before that edge was an accept or a stall.
   task automatic tick();
      b_acc = req_valid & req_ready;
      if (req_valid & req_ready) n_iss++;
      if (req_valid & ~req_ready) n_stl++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input int tag);
      req_valid = 1'b1;
      req_inst  = op;
      req_a     = a;
      req_b     = b;
      req_c     = c;
      req_tag   = TAG_W'(tag);
   endtask

   // Eight LT ops (A=i, B=4, tag=i) against a stalled consumer, then release.
   task automatic run_stream();
      int i;
      int k;
      i = 0;
      k = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (i < 8) drive(OP_LT, 32'(i), 32'd4, 32'd0, i);
         tick();
         if (b_acc) i++;
      end
      chk("stream_accepts_before_full", 32'(i), 32'd4);
      chk("stream_ready_when_full", 32'(req_ready), 32'd0);
      chk("stream_rsp_valid_full", 32'(rsp_valid), 32'd1);
      chk("stream_head_tag_full", 32'(rsp_tag), 32'd0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && k < 8; c++) begin
         if (rsp_valid) begin
            chk("stream_rsp_tag", 32'(rsp_tag), 32'(k));
            chk("stream_rsp_compare", 32'(rsp_compare), (k < 4) ? 32'd1 : 32'd0);
            k++;
         end
         if (i < 8) drive(OP_LT, 32'(i), 32'd4, 32'd0, i);
         else req_valid = 1'b0;
         tick();
         if (b_acc) i++;
      end
      chk("stream_all_responses", 32'(k), 32'd8);
      chk("stream_all_accepted", 32'(i), 32'd8);
      req_valid = 1'b0;
      tick();
      chk("stream_drained", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_inst   = 6'd0;
      req_a      = 32'd0;
      req_b      = 32'd0;
      req_c      = 32'd0;
      req_select = 1'b0;
      req_tag    = '0;
      rsp_ready  = 1'b1;

      // Reset state
      #2;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_fu_inst", 32'(fu_inst), 32'd0);
      chk("rst_rsp_z", rsp_z, 32'd0);
      chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 32'(req_ready), 32'd1);

      // Single ADD: 5 + 7, tag 3
      drive(OP_ADD, 32'd5, 32'd7, 32'd0, 3);
      tick();
      req_valid = 1'b0;
      chk("add_fu_inst_before_fall", 32'(fu_inst), 32'd0);
      @(negedge clk);
      #1;
      chk("add_fu_inst_after_fall", 32'(fu_inst), 32'(OP_ADD));
      chk("add_fu_a", fu_a, 32'd5);
      chk("add_fu_b", fu_b, 32'd7);
      tick();
      chk("add_rsp_valid_t1", 32'(rsp_valid), 32'd0);
      tick();
      chk("add_rsp_valid_t2", 32'(rsp_valid), 32'd1);
      chk("add_rsp_z", rsp_z, 32'd12);
      chk("add_rsp_tag", 32'(rsp_tag), 32'd3);
      tick();
      chk("add_popped", 32'(rsp_valid), 32'd0);
      chk("add_hold_z", rsp_z, 32'd12);

      // MADD 3*4+10 with an INC (A=9) held valid behind it
      drive(OP_MADD, 32'd3, 32'd4, 32'd10, 5);
      tick();
      drive(OP_INC, 32'd9, 32'd0, 32'd0, 6);
      chk("madd_ready_t0", 32'(req_ready), 32'd0);
      tick();
      chk("madd_ready_t1", 32'(req_ready), 32'd0);
      tick();
      chk("madd_ready_t2", 32'(req_ready), 32'd0);
      tick();
      chk("madd_ready_t3", 32'(req_ready), 32'd0);
      chk("madd_rsp_valid_t3", 32'(rsp_valid), 32'd0);
      tick();
      chk("madd_rsp_valid_t4", 32'(rsp_valid), 32'd1);
      chk("madd_rsp_z", rsp_z, 32'd22);
      chk("madd_rsp_tag", 32'(rsp_tag), 32'd5);
      chk("madd_ready_t4", 32'(req_ready), 32'd1);
      tick();
      chk("inc_accepted", 32'(b_acc), 32'd1);
      req_valid = 1'b0;
      chk("madd_popped", 32'(rsp_valid), 32'd0);
      tick();
      chk("inc_rsp_valid_t1", 32'(rsp_valid), 32'd0);
      tick();
      chk("inc_rsp_valid_t2", 32'(rsp_valid), 32'd1);
      chk("inc_rsp_z", rsp_z, 32'd10);
      chk("inc_rsp_tag", 32'(rsp_tag), 32'd6);
      tick();
      chk("inc_popped", 32'(rsp_valid), 32'd0);

      // Mixed: ADD 1+2 (tag 7) at t, MADD 2*5+1 (tag 8) at t+1
      drive(OP_ADD, 32'd1, 32'd2, 32'd0, 7);
      tick();
      drive(OP_MADD, 32'd2, 32'd5, 32'd1, 8);
      tick();
      chk("mix_madd_accepted", 32'(b_acc), 32'd1);
      req_valid = 1'b0;
      chk("mix_ready_wait", 32'(req_ready), 32'd0);
      tick();
      chk("mix_add_valid", 32'(rsp_valid), 32'd1);
      chk("mix_add_z", rsp_z, 32'd3);
      chk("mix_add_tag", 32'(rsp_tag), 32'd7);
      tick();
      chk("mix_gap_t3", 32'(rsp_valid), 32'd0);
      tick();
      chk("mix_gap_t4", 32'(rsp_valid), 32'd0);
      tick();
      chk("mix_madd_valid", 32'(rsp_valid), 32'd1);
      chk("mix_madd_z", rsp_z, 32'd11);
      chk("mix_madd_tag", 32'(rsp_tag), 32'd8);
      chk("mix_ready_back", 32'(req_ready), 32'd1);
      tick();
      chk("mix_popped", 32'(rsp_valid), 32'd0);

      // Streaming into backpressure
      run_stream();

      // Reset with a MADD in flight and two FIFO entries held
      rsp_ready = 1'b0;
      drive(OP_ADD, 32'd1, 32'd1, 32'd0, 1);
      tick();
      drive(OP_ADD, 32'd2, 32'd2, 32'd0, 2);
      tick();
      drive(OP_MADD, 32'd2, 32'd2,32'd2, 3);
      tick();
      req_valid = 1'b0;
      tick();
      chk("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("prerst_ready", 32'(req_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_fu_inst", 32'(fu_inst), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_rsp_z", rsp_z, 32'd0);
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick();
      chk("rel_ready", 32'(req_ready), 32'd1);
      chk("rel_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("rel_no_stale_rsp", 32'(rsp_valid), 32'd0);
      end
      chk("rel_fu_inst", 32'(fu_inst), 32'd0);

`ifdef FU_SEQ_STATS_EN
      // Stats: repeat the streaming run from a fresh reset
      rst_n = 1'b0;
      #1;
      tick();
      #2;
      rst_n = 1'b1;
      tick();
      n_iss = 0;
      n_stl = 0;
      chk("stats_rst_issue", 32'(stat_issue), 32'd0);
      run_stream();
      chk("stats_issue", 32'(stat_issue), 32'd8);
      chk("stats_stall", 32'(stat_stall), 32'(n_stl));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
